// File: rtl/mode_select_sequencer_if.sv
// rtl/mode_select_sequencer_if.sv - button/hold inputs and mode outputs of the mode select sequencer
//
// Signals:
//   btn_next_raw  raw asynchronous NEXT pushbutton (1 = pressed)
//   btn_prev_raw  raw asynchronous PREV pushbutton (1 = pressed)
//   hold          discard press events and freeze the mode while 1
//   mode_select   current 3-bit mode code (registered)
//   mode_changed  one-cycle pulse whenever an event is applied to mode_select
// Modports: master drives the buttons and hold, slave is the sequencer.

interface mode_select_sequencer_if;
    logic       btn_next_raw;
    logic       btn_prev_raw;
    logic       hold;
    logic [2:0] mode_select;
    logic       mode_changed;

    modport master (
        output btn_next_raw,
        output btn_prev_raw,
        output hold,
        input  mode_select,
        input  mode_changed
    );

    modport slave (
        input  btn_next_raw,
        input  btn_prev_raw,
        input  hold,
        output mode_select,
        output mode_changed
    );
endinterface

// File: rtl/mode_select_sequencer.sv
// rtl/mode_select_sequencer.sv - debounced NEXT/PREV buttons stepping a wrap-around mode register
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synchronised level must persist before acceptance (>= 1)
//   NUM_MODES        number of modes, 2..8
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-low reset
//   bus    mode_select_sequencer_if.slave (buttons, hold, mode_select, mode_changed)

module mode_select_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int NUM_MODES       = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    mode_select_sequencer_if.slave      bus
);

    localparam int             CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]     MODE_LAST = 3'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } db_state_t;

    // Index 0 = NEXT, index 1 = PREV.
    logic [1:0]    raw;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    stable;
    logic [1:0]    stable_q;
    logic [1:0]    press;
    db_state_t     state [2];
    logic [CW-1:0] cnt   [2];

    logic [2:0]    mode_q;
    logic          changed_q;

    assign raw   = {bus.btn_prev_raw, bus.btn_next_raw};
    assign press = stable & ~stable_q;

    assign bus.mode_select  = mode_q;
    assign bus.mode_changed = changed_q;

    // Synchronisers and debouncers for both buttons.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < 2; i++) begin
                state[i] <= STABLE_LOW;
                cnt[i]   <= '0;
            end
        end else begin
            s1       <= raw;
            s2       <= s1;
            stable_q <= stable;
            for (int i = 0; i < 2; i++) begin
                case (state[i])
                    STABLE_LOW: begin
                        if (s2[i]) begin
                            // A one-cycle debounce accepts the first differing sample.
                            if (DEBOUNCE_CYCLES == 1) begin
                                state[i]  <= STABLE_HIGH;
                                stable[i] <= 1'b1;
                                cnt[i]    <= '0;
                            end else begin
                                state[i] <= WAIT_HIGH;
                                cnt[i]   <= CNT_ONE;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (!s2[i]) begin
                            state[i] <= STABLE_LOW;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]  <= STABLE_HIGH;
                            stable[i] <= 1'b1;
                            cnt[i]    <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    STABLE_HIGH: begin
                        if (!s2[i]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state[i]  <= STABLE_LOW;
                                stable[i] <= 1'b0;
                                cnt[i]    <= '0;
                            end else begin
                                state[i] <= WAIT_LOW;
                                cnt[i]   <= CNT_ONE;
                            end
                        end
                    end
                    WAIT_LOW: begin
                        if (s2[i]) begin
                            state[i] <= STABLE_HIGH;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]  <= STABLE_LOW;
                            stable[i] <= 1'b0;
                            cnt[i]    <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[i] <= STABLE_LOW;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Mode register. Events arriving while hold is high are dropped, not queued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q    <= 3'd0;
            changed_q <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            if (!bus.hold) begin
                if (press[0] && press[1]) begin
                    // Both buttons at once means "go to OFF", pulsing even if already OFF.
                    mode_q    <= 3'd0;
                    changed_q <= 1'b1;
                end else if (press[0]) begin
                    mode_q    <= (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
                    changed_q <= 1'b1;
                end else if (press[1]) begin
                    mode_q    <= (mode_q == 3'd0) ? MODE_LAST : mode_q - 3'd1;
                    changed_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mode_select_sequencer.sv
// tb/tb_mode_select_sequencer.sv - directed self-checking bench for mode_select_sequencer

module tb_mode_select_sequencer;

    localparam int DB  = 4;
    localparam int NM  = 6;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   pulse_count;

    mode_select_sequencer_if bus_if ();

    mode_select_sequencer #(
        .DEBOUNCE_CYCLES (DB),
        .NUM_MODES       (NM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count mode_changed pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_if.mode_changed === 1'b1)
            pulse_count <= pulse_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ticks(3);
        reset = 1'b1;
    endtask

    task automatic press_next();
        bus_if.btn_next_raw = 1'b1;
        ticks(10);
        bus_if.btn_next_raw = 1'b0;
        ticks(10);
    endtask

    task automatic press_prev();
        bus_if.btn_prev_raw = 1'b1;
        ticks(10);
        bus_if.btn_prev_raw = 1'b0;
        ticks(10);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_if.btn_next_raw = i[0];
            bus_if.btn_prev_raw = ~i[0];
            tick();
            tests++;
            if (bus_if.mode_select !== 3'd0 || bus_if.mode_changed !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold cycle %0d: mode=%0d changed=%b, want mode=0 changed=0",
                         i, bus_if.mode_select, bus_if.mode_changed);
            end
        end
        bus_if.btn_next_raw = 1'b0;
        bus_if.btn_prev_raw = 1'b0;
        reset = 1'b1;
        tick();
        tests++;
        if (bus_if.mode_select !== 3'd0 || bus_if.mode_changed !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: mode=%0d changed=%b, want mode=0 changed=0",
                     bus_if.mode_select, bus_if.mode_changed);
        end
        ticks(10);
    endtask

    task automatic test_latency();
        int p0;
        p0 = pulse_count;
        bus_if.btn_next_raw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            tests++;
            if (bus_if.mode_select !== 3'd0 || bus_if.mode_changed !== 1'b0) begin
                fails++;
                $display("FAIL latency_early tick %0d: mode=%0d changed=%b, want mode=0 changed=0",
                         k, bus_if.mode_select, bus_if.mode_changed);
            end
        end
        tick();
        tests++;
        if (bus_if.mode_select !== 3'd1 || bus_if.mode_changed !== 1'b1) begin
            fails++;
            $display("FAIL latency_edge7: mode=%0d changed=%b, want mode=1 changed=1",
                     bus_if.mode_select, bus_if.mode_changed);
        end
        tick();
        tests++;
        if (bus_if.mode_changed !== 1'b0) begin
            fails++;
            $display("FAIL latency_pulse_width: changed=%b, want 0", bus_if.mode_changed);
        end
        ticks(12);
        bus_if.btn_next_raw = 1'b0;
        ticks(15);
        tests++;
        if (bus_if.mode_select !== 3'd1 || pulse_count - p0 !== 1) begin
            fails++;
            $display("FAIL latency_release: mode=%0d pulses=%0d, want mode=1 pulses=1",
                     bus_if.mode_select, pulse_count - p0);
        end
    endtask

    task automatic test_wrap();
        logic [2:0] want [6];
        int p0;
        want = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            p0 = pulse_count;
            press_next();
            tests++;
            if (bus_if.mode_select !== want[i] || pulse_count - p0 !== 1) begin
                fails++;
                $display("FAIL wrap_next press %0d: mode=%0d pulses=%0d, want mode=%0d pulses=1",
                         i, bus_if.mode_select, pulse_count - p0, want[i]);
            end
        end
        p0 = pulse_count;
        press_prev();
        tests++;
        if (bus_if.mode_select !== 3'd5 || pulse_count - p0 !== 1) begin
            fails++;
            $display("FAIL wrap_prev: mode=%0d pulses=%0d, want mode=5 pulses=1",
                     bus_if.mode_select, pulse_count - p0);
        end
    endtask

    task automatic test_bounce();
        int p0;
        do_reset();
        p0 = pulse_count;
        for (int w = 1; w <= 3; w++) begin
            bus_if.btn_next_raw = 1'b1;
            ticks(w);
            bus_if.btn_next_raw = 1'b0;
            ticks(2);
        end
        ticks(4);
        tests++;
        if (bus_if.mode_select !== 3'd0 || pulse_count - p0 !== 0) begin
            fails++;
            $display("FAIL bounce_glitches: mode=%0d pulses=%0d, want mode=0 pulses=0",
                     bus_if.mode_select, pulse_count - p0);
        end
        bus_if.btn_next_raw = 1'b1;
        ticks(10);
        bus_if.btn_next_raw = 1'b0;
        ticks(12);
        tests++;
        if (bus_if.mode_select !== 3'd1 || pulse_count - p0 !== 1) begin
            fails++;
            $display("FAIL bounce_accept: mode=%0d pulses=%0d, want mode=1 pulses=1",
                     bus_if.mode_select, pulse_count - p0);
        end
    endtask

    task automatic test_simultaneous();
        int p0;
        do_reset();
        repeat (3) press_next();
        tests++;
        if (bus_if.mode_select !== 3'd3) begin
            fails++;
            $display("FAIL simul_setup: mode=%0d, want 3", bus_if.mode_select);
        end
        for (int r = 0; r < 2; r++) begin
            p0 = pulse_count;
            bus_if.btn_next_raw = 1'b1;
            bus_if.btn_prev_raw = 1'b1;
            ticks(10);
            bus_if.btn_next_raw = 1'b0;
            bus_if.btn_prev_raw = 1'b0;
            ticks(10);
            tests++;
            if (bus_if.mode_select !== 3'd0 || pulse_count - p0 !== 1) begin
                fails++;
                $display("FAIL simul_round %0d: mode=%0d pulses=%0d, want mode=0 pulses=1",
                         r, bus_if.mode_select, pulse_count - p0);
            end
        end
    endtask

    task automatic test_hold();
        int p0;
        do_reset();
        repeat (2) press_next();
        p0 = pulse_count;
        bus_if.hold = 1'b1;
        bus_if.btn_next_raw = 1'b1;
        ticks(10);
        bus_if.hold = 1'b0;
        ticks(5);
        tests++;
        if (bus_if.mode_select !== 3'd2 || pulse_count - p0 !== 0) begin
            fails++;
            $display("FAIL hold_drop: mode=%0d pulses=%0d, want mode=2 pulses=0",
                     bus_if.mode_select, pulse_count - p0);
        end
        bus_if.btn_next_raw = 1'b0;
        ticks(10);
        p0 = pulse_count;
        press_next();
        tests++;
        if (bus_if.mode_select !== 3'd3 || pulse_count - p0 !== 1) begin
            fails++;
            $display("FAIL hold_after: mode=%0d pulses=%0d, want mode=3 pulses=1",
                     bus_if.mode_select, pulse_count - p0);
        end
    endtask

    task automatic test_reset_mid_press();
        int p0;
        do_reset();
        p0 = pulse_count;
        bus_if.btn_next_raw = 1'b1;
        ticks(4);
        reset = 1'b0;
        ticks(2);
        bus_if.btn_next_raw = 1'b0;
        reset = 1'b1;
        ticks(15);
        tests++;
        if (bus_if.mode_select !== 3'd0 || pulse_count - p0 !== 0) begin
            fails++;
            $display("FAIL reset_mid_press: mode=%0d pulses=%0d, want mode=0 pulses=0",
                     bus_if.mode_select, pulse_count - p0);
        end
        // Button held across reset release counts as a fresh press.
        bus_if.btn_next_raw = 1'b1;
        reset = 1'b0;
        ticks(2);
        reset = 1'b1;
        ticks(6);
        tests++;
        if (bus_if.mode_select !== 3'd0) begin
            fails++;
            $display("FAIL held_through_reset_early: mode=%0d, want 0", bus_if.mode_select);
        end
        tick();
        tests++;
        if (bus_if.mode_select !== 3'd1 || bus_if.mode_changed !== 1'b1) begin
            fails++;
            $display("FAIL held_through_reset: mode=%0d changed=%b, want mode=1 changed=1",
                     bus_if.mode_select, bus_if.mode_changed);
        end
        bus_if.btn_next_raw = 1'b0;
        ticks(10);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        pulse_count = 0;
        reset = 1'b0;
        bus_if.btn_next_raw = 1'b0;
        bus_if.btn_prev_raw = 1'b0;
        bus_if.hold = 1'b0;

        test_reset();
        test_latency();
        test_wrap();
        test_bounce();
        test_simultaneous();
        test_hold();
        test_reset_mid_press();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mode_select_sequencer.md
# mode_select_sequencer

Generates the 3-bit `mode_select` code consumed by the output-mode FSM from two raw front-panel pushbuttons, NEXT and PREV. It synchronises and debounces each button, converts clean presses into single-cycle events, and steps a wrap-around mode register through 0..NUM_MODES-1. It sits between the board button pins and the output-mode FSM, and drives that FSM's `mode_select` input directly.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles a synchronised level must differ from the debounced level before it is accepted (10 ms at 100 MHz); legal range ≥ 1.
- `NUM_MODES`, default 6: number of modes (0 = OFF, 1 = PWM, 2 = R2R, 3 = SAWTOOTH, 4 = BUZZER, 5 = CHIRP); legal range 2..8.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; asserted when 0).
- `btn_next_raw`  in  1  asynchronous NEXT pushbutton; 1 = pressed.
- `btn_prev_raw`  in  1  asynchronous PREV pushbutton; 1 = pressed.
- `hold`  in  1  synchronous; when 1, press events are discarded and the mode is frozen.
- `mode_select`  out  3  current mode code, registered.
- `mode_changed`  out  1  one-cycle pulse, registered, on every cycle in which an event is applied to `mode_select`.

## Operation
- **Synchroniser:** each raw button passes through a 2-flop synchroniser, giving `s1` then `s2`.
- **Debouncer:** one per button, with a counter of width $clog2(DEBOUNCE_CYCLES+1) and a `stable` flag. States:
  - STABLE_LOW: `stable` = 0. If `s2` = 1, go to WAIT_HIGH with the counter = 1.
  - WAIT_HIGH:
    - `s2` = 0 → return to STABLE_LOW and clear the counter.
    - `s2` = 1 and counter = DEBOUNCE_CYCLES-1 → go to STABLE_HIGH (`stable` ← 1) and clear the counter.
    - Otherwise increment the counter.
  - STABLE_HIGH and WAIT_LOW: mirror STABLE_LOW and WAIT_HIGH with polarity inverted.
  - With DEBOUNCE_CYCLES = 1, a single differing `s2` sample is accepted.
- **Press event:** `stable` rises 0→1 (compared with its registered copy). Releases generate no event.
- **Event resolution** (only when `hold` = 0):
  - next only: `mode_select` ← (`mode_select` = NUM_MODES-1) ? 0 : `mode_select` + 1.
  - prev only: `mode_select` ← (`mode_select` = 0) ? NUM_MODES-1 : `mode_select` - 1.
  - next and prev in the same cycle: `mode_select` ← 0 (OFF). `mode_changed` pulses even if the value was already 0.
- When `hold` = 1, events in that cycle are dropped, not queued. Debouncers keep running, so a press that completes under hold is lost.
- `mode_select` never leaves 0..NUM_MODES-1.
- Arithmetic is 3-bit. The comparison is against NUM_MODES-1 cast to 3 bits, so NUM_MODES = 8 wraps 7→0.

## Timing
- **Reset** (`reset` = 0 at a rising edge):
  - `mode_select` = 0, `mode_changed` = 0.
  - Synchronisers = 0, `stable` = 0, counters = 0, debouncers in STABLE_LOW.
- **Reset mid-operation:** reset mid-debounce or mid-press aborts it. No event is produced from pre-reset history.
- **Button held through reset release:** counts as a new press once debounced after release.
- **Latency:** raw input high and steady, first sampled at edge E0:
  - `s2` = 1 after E1.
  - `stable` = 1 after E(DEBOUNCE_CYCLES+1).
  - `mode_select` and `mode_changed` update after E(DEBOUNCE_CYCLES+2), i.e. DEBOUNCE_CYCLES+3 edges including E0.
- `mode_changed` is high for exactly one cycle per applied event.
- **Back-to-back presses:** separated by at least 2·DEBOUNCE_CYCLES+2 cycles; no events are lost.
- **Bounce:** a glitch shorter than DEBOUNCE_CYCLES cycles (at `s2`) produces no event and restarts the count.

## Test plan
- **Reset:** apply `reset` = 0 for 3 cycles with both buttons toggling → `mode_select` = 0 and `mode_changed` = 0 throughout and on the first cycle after release.
- **Single press latency** (DEBOUNCE_CYCLES = 4): `btn_next_raw` 0→1 held 20 cycles from mode 0 → `mode_select` = 1 and one `mode_changed` pulse, exactly 7 edges after the first sampling edge. Release produces no further change.
- **Wrap-around** (NUM_MODES = 6):
  - 6 clean NEXT presses from 0 → sequence 1, 2, 3, 4, 5, 0.
  - 1 PREV press from 0 → 5.
- **Bounce rejection** (DEBOUNCE_CYCLES = 4): NEXT pulses of 1, 2, 3 cycles separated by 2 low cycles, then 10 cycles high → exactly one increment, no earlier `mode_changed`.
- **Simultaneous presses:** NEXT and PREV asserted on the same cycle from mode 3 → `mode_select` = 0, one `mode_changed` pulse.
- **Hold:**
  - `hold` = 1 across a full NEXT press from mode 2 → `mode_select` stays 2, no pulse.
  - Deassert `hold` with the button still held → no event.
  - Next press after release → 3.
